// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
package stream_demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

endpackage

// File: rtl/stream_demux_if.sv
// Valid/ready bundle between one producer, the demux and four consumers.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
   parameter int W = 4
);

   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       in_data;
   logic [SEL_W-1:0]   sel;
   logic [N_OUT-1:0]   out_valid;
   logic [N_OUT-1:0]   out_ready;
   logic [W-1:0]       y0;
   logic [W-1:0]       y1;
   logic [W-1:0]       y2;
   logic [W-1:0]       y3;

   // Environment side: producer plus the four consumers.
   modport master (
      output in_valid, in_data, sel, out_ready,
      input  in_ready, out_valid, y0, y1, y2, y3
   );

   // Demux side.
   modport slave (
      input  in_valid, in_data, sel, out_ready,
      output in_ready, out_valid, y0, y1, y2, y3
   );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output register slot: accepts a word on fill, presents it until drained.
module stream_demux_slot
   import stream_demux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         fill,
   input  logic         out_ready,
   input  logic [W-1:0] data,
   output logic         valid,
   output logic [W-1:0] q,
   output logic         can_accept
);

   slot_state_t state_q;
   slot_state_t state_d;
   logic        drain;

   assign valid      = (state_q == SLOT_FULL);
   assign drain      = valid && out_ready;
   assign can_accept = !valid || drain;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SLOT_EMPTY;
      else        state_q <= state_d;
   end

   // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      if (state_q == SLOT_EMPTY) begin
         if (fill) state_d = SLOT_FULL;
      end else begin
         if (drain && !fill) state_d = SLOT_EMPTY;
      end
   end

   // NOTE: the data register is reset too, so y reads 0 right after reset rather than X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= '0;
      else if (fill) q <= data;
   end

endmodule

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready demultiplexer with a registered slot per output channel.
// Optional per-channel fill counters on port cnt when STREAM_DEMUX_1_4_CNT_EN is defined.
module stream_demux_1_4
   import stream_demux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef STREAM_DEMUX_1_4_CNT_EN
   output logic [N_OUT*CNT_W-1:0] cnt,
`endif
   stream_demux_if.slave        bus
);

   logic [N_OUT-1:0] fill;
   logic [N_OUT-1:0] can_accept;
   logic [W-1:0]     q [N_OUT];
   logic             in_ready;

   // Readiness follows only the addressed slot, so a stalled channel never blocks the others.
   assign in_ready     = can_accept[bus.sel];
   assign bus.in_ready = in_ready;

   for (genvar i = 0; i < N_OUT; i++) begin : g_slot
      assign fill[i] = bus.in_valid && in_ready && (bus.sel == SEL_W'(i));

      stream_demux_slot #(.W(W)) u_slot (
         .clk        (clk),
         .rst_n      (rst_n),
         .fill       (fill[i]),
         .out_ready  (bus.out_ready[i]),
         .data       (bus.in_data),
         .valid      (bus.out_valid[i]),
         .q          (q[i]),
         .can_accept (can_accept[i])
      );
   end

   assign bus.y0 = q[0];
   assign bus.y1 = q[1];
   assign bus.y2 = q[2];
   assign bus.y3 = q[3];

`ifdef STREAM_DEMUX_1_4_CNT_EN
   logic [CNT_W-1:0] cnt_q [N_OUT];

   for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
      // Free-running field; natural 8-bit overflow gives the 255 -> 0 wrap.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)       cnt_q[i] <= '0;
         else if (fill[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
      assign cnt[i*CNT_W +: CNT_W] = cnt_q[i];
   end
`endif

endmodule
